secventiator_intersectie: RTL

Master sequencer for the automatic intersection: runs the vehicle signal cycle, latches pedestrian requests, and produces the phase counter and enable consumed by the pedestrian light controller (`counter`, `enable_i`, `w_p` inputs of that stage). It sits directly upstream of the pedestrian controller and owns all intersection timing. The pedestrian stage only decodes the count it receives.

---
 rtl/secventiator_intersectie.sv | 123 ++++++++++++
 1 files changed

// File: rtl/secventiator_intersectie.sv
// rtl/secventiator_intersectie.sv - master sequencer for the automatic intersection
//
// Runs the vehicle signal cycle (green, yellow, all-red, pedestrian, all-red),
// latches pedestrian requests and drives the phase timer consumed by the
// pedestrian light controller.
//
// Ports:
//   clk_i         in   system clock
//   rst_i         in   asynchronous active-high reset
//   btn_i         in   pedestrian push-button, synchronous, level-sensitive
//   Rosu_auto_o   out  vehicle red
//   Galben_auto_o out  vehicle yellow
//   Verde_auto_o  out  vehicle green
//   counter_o     out  5-bit phase timer, cleared on every state entry
//   enable_o      out  high only during the pedestrian phase
//   w_p_o         out  pedestrian request pending

module secventiator_intersectie #(
  parameter int CAR_GREEN_MIN = 20,
  parameter int CAR_GREEN_MAX = 30,
  parameter int CAR_YELLOW    = 3,
  parameter int ALL_RED       = 1,
  parameter int PED_LEN       = 19
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       btn_i,
  output logic       Rosu_auto_o,
  output logic       Galben_auto_o,
  output logic       Verde_auto_o,
  output logic [4:0] counter_o,
  output logic       enable_o,
  output logic       w_p_o
);

  localparam logic [2:0] S_CAR_GREEN  = 3'd0;
  localparam logic [2:0] S_CAR_YELLOW = 3'd1;
  localparam logic [2:0] S_RED_PRE    = 3'd2;
  localparam logic [2:0] S_PED        = 3'd3;
  localparam logic [2:0] S_RED_POST   = 3'd4;

  // Last count value of each phase; a phase of length N runs 0..N-1.
  localparam logic [4:0] GREEN_MIN_LAST = 5'(CAR_GREEN_MIN - 1);
  localparam logic [4:0] GREEN_MAX_LAST = 5'(CAR_GREEN_MAX - 1);
  localparam logic [4:0] YELLOW_LAST    = 5'(CAR_YELLOW - 1);
  localparam logic [4:0] ALL_RED_LAST   = 5'(ALL_RED - 1);
  localparam logic [4:0] PED_LAST       = 5'(PED_LEN - 1);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic [4:0] count_q;
  logic       req_q;
  logic       req_d;
  logic       leave;

  // Phase end detection and next-state selection.
  always_comb begin
    state_d = state_q;
    leave   = 1'b0;
    case (state_q)
      S_CAR_GREEN: begin
        // A pending request may cut green short once the minimum is served;
        // otherwise green is forced to end at the maximum.
        leave   = ((count_q >= GREEN_MIN_LAST) && req_q) || (count_q == GREEN_MAX_LAST);
        state_d = S_CAR_YELLOW;
      end
      S_CAR_YELLOW: begin
        leave   = (count_q == YELLOW_LAST);
        state_d = S_RED_PRE;
      end
      S_RED_PRE: begin
        leave   = (count_q == ALL_RED_LAST);
        state_d = S_PED;
      end
      S_PED: begin
        leave   = (count_q == PED_LAST);
        state_d = S_RED_POST;
      end
      S_RED_POST: begin
        leave   = (count_q == ALL_RED_LAST);
        state_d = S_CAR_GREEN;
      end
      default: begin
        leave   = 1'b1;
        state_d = S_CAR_GREEN;
      end
    endcase
    if (!leave) begin
      state_d = state_q;
    end
  end

  // Request latch: entering PED clears it and beats a simultaneous press;
  // presses during PED (including its last cycle) are dropped.
  always_comb begin
    req_d = req_q;
    if (state_q == S_RED_PRE && leave) begin
      req_d = 1'b0;
    end else if (state_q != S_PED && btn_i) begin
      req_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_CAR_GREEN;
      count_q <= 5'd0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= leave ? 5'd0 : count_q + 5'd1;
      req_q   <= req_d;
    end
  end

  assign Verde_auto_o  = (state_q == S_CAR_GREEN);
  assign Galben_auto_o = (state_q == S_CAR_YELLOW);
  assign Rosu_auto_o   = !(Verde_auto_o || Galben_auto_o);
  assign enable_o      = (state_q == S_PED);
  assign counter_o     = count_q;
  assign w_p_o         = req_q;

endmodule
